// File: rtl/multiplier_controller_pkg.sv
// Shared definitions for the repeated-addition multiplier: default width,
// FSM state encodings and the datapath control bundle.
package multiplier_controller_pkg;

  localparam int WIDTH_DEF = 5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDB  = 3'd1,
    S_ADD  = 3'd2,
    S_DONE = 3'd3
  } state_t;

  // Strobes from the FSM into mult_datapath
  typedef struct packed {
    logic lda;     // capture operand A
    logic ldb;     // capture operand B into the counter
    logic clrp;    // clear the product accumulator
    logic addp;    // product += A
    logic deccnt;  // cnt -= 1
  } dp_ctrl_t;

endpackage

// File: rtl/multiplier_controller_if.sv
// Operand/result bus of the multiplier. The master drives start and the
// shared operand bus; the slave (multiplier) returns product, busy and done.
interface multiplier_controller_if #(
  parameter int WIDTH = 5
);
  logic               start;
  logic [WIDTH-1:0]   data_in;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  modport master (output start, data_in, input product, busy, done);
  modport slave  (input start, data_in, output product, busy, done);
endinterface

// File: rtl/multiplier_controller_datapath.sv
// mult_datapath: A register, cnt down-counter, product accumulator and the
// cnt==0 detect. With MUL_SWAP_EN defined, loading B compares it against A
// and puts the smaller value in the counter so fewer additions are needed.
module mult_datapath
  import multiplier_controller_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   data_in,
  input  dp_ctrl_t           ctrl,
  output logic [2*WIDTH-1:0] product,
  output logic               eqz
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] cnt;

  assign eqz = (cnt == '0);

  // Operand capture, counter and accumulator; the FSM never asserts
  // lda/ldb or clrp/addp together, so the priorities below are only nominal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (ctrl.lda) a <= data_in;
      if (ctrl.ldb) begin
`ifdef MUL_SWAP_EN
        if (data_in < a) begin
          cnt <= data_in;
        end else begin
          cnt <= a;
          a   <= data_in;
        end
`else
        cnt <= data_in;
`endif
      end else if (ctrl.deccnt) begin
        cnt <= cnt - 1'b1;
      end
      if (ctrl.clrp)      product <= '0;
      else if (ctrl.addp) product <= product + {{WIDTH{1'b0}}, a};
    end
  end

endmodule

// File: rtl/multiplier_controller.sv
// multiplier_controller: sequential multiplier by repeated addition.
// A arrives on data_in with start, B on the following cycle; the product is
// held while done=1. Optional macro MUL_SWAP_EN (in mult_datapath) iterates
// min(A,B) times instead of B times.
module multiplier_controller
  import multiplier_controller_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  multiplier_controller_if.slave bus
);

  state_t   state_q, state_d;
  dp_ctrl_t ctrl;
  logic     eqz;

  mult_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .data_in (bus.data_in),
    .ctrl    (ctrl),
    .product (bus.product),
    .eqz     (eqz)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath strobes; start only matters in IDLE and DONE
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          ctrl.lda = 1'b1;
          state_d  = S_LDB;
        end
      end
      S_LDB: begin
        ctrl.ldb  = 1'b1;
        ctrl.clrp = 1'b1;
        state_d   = S_ADD;
      end
      S_ADD: begin
        if (!eqz) begin
          ctrl.addp   = 1'b1;
          ctrl.deccnt = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded straight from the state register
  assign bus.busy = (state_q == S_LDB) || (state_q == S_ADD);
  assign bus.done = (state_q == S_DONE);

endmodule
